// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/busy/done handshake bundle for bin2bcd_seq
// Purpose: groups the conversion request and result signals of bin2bcd_seq.
// Signals: start, data[DATA_W] (request side); busy, done, bcd_data[4*DIGITS],
//          overflow, and blank_mask[DIGITS] when LZ_BLANK_EN is defined (result side).
// Modports: master drives requests, slave is the converter.
// Optional feature macro: LZ_BLANK_EN.
interface bin2bcd_seq_if #(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
);
    logic                  start;
    logic [DATA_W-1:0]     data;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_data;
    logic                  overflow;
`ifdef LZ_BLANK_EN
    logic [DIGITS-1:0]     blank_mask;

    modport master (output start, data, input busy, done, bcd_data, overflow, blank_mask);
    modport slave  (input start, data, output busy, done, bcd_data, overflow, blank_mask);
`else
    modport master (output start, data, input busy, done, bcd_data, overflow);
    modport slave  (input start, data, output busy, done, bcd_data, overflow);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter
// Purpose: converts an unsigned DATA_W-bit value into DIGITS BCD digits, one
//          adjust+shift per clock, with overflow saturation to all nines.
// Ports: sys_clk    - system clock
//        sys_rst_n  - asynchronous active-low reset
//        bus        - bin2bcd_seq_if.slave (start, data, busy, done, bcd_data,
//                     overflow, blank_mask with LZ_BLANK_EN)
// Optional feature macro: LZ_BLANK_EN (leading-zero blanking mask output).
module bin2bcd_seq #(
    parameter  int DATA_W = 20,
    parameter  int DIGITS = 6,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q;
    logic [SR_W-1:0]    sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_sticky_q;
    logic               busy_q;
    logic               done_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               overflow_q;

    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_d;
    logic               shout;

    // Add-3 on every digit field above 4, then shift the whole register left.
    // The bit leaving the top digit means the value no longer fits in DIGITS.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_q[DATA_W+4*i +: 4] > 4'd4) begin
                sr_adj[DATA_W+4*i +: 4] = sr_q[DATA_W+4*i +: 4] + 4'd3;
            end
        end
        shout = sr_adj[SR_W-1];
        sr_d  = {sr_adj[SR_W-2:0], 1'b0};
    end

`ifdef LZ_BLANK_EN
    logic [DIGITS-1:0]  blank_q;
    logic [DIGITS-1:0]  blank_d;
    logic               zero_above;

    // Digit i blanks when it and every higher digit are zero; the units
    // digit never blanks so a zero result still shows one "0".
    always_comb begin
        blank_d    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (sr_q[DATA_W+4*i +: 4] == 4'd0);
            blank_d[i] = zero_above & ~ovf_sticky_q;
        end
    end

    assign bus.blank_mask = blank_q;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            ovf_sticky_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bcd_q        <= '0;
            overflow_q   <= 1'b0;
`ifdef LZ_BLANK_EN
            blank_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sr_q         <= {{BCD_W{1'b0}}, bus.data};
                        cnt_q        <= '0;
                        ovf_sticky_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q         <= sr_d;
                    ovf_sticky_q <= ovf_sticky_q | shout;
                    cnt_q        <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_q      <= ovf_sticky_q ? {DIGITS{4'h9}} : sr_q[SR_W-1:DATA_W];
                    overflow_q <= ovf_sticky_q;
`ifdef LZ_BLANK_EN
                    blank_q    <= blank_d;
`endif
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_data = bcd_q;
    assign bus.overflow = overflow_q;

endmodule
